// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_INC  = 4;

  typedef enum logic [1:0] {
    StBoot,
    StReq,
    StHold,
    StDrop
  } state_e;

endpackage

// File: rtl/adder.sv
// Plain N-bit adder; carry out is dropped so results wrap modulo 2^N.
module adder #(
  parameter int unsigned N = 64
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] y_o
);

  assign y_o = a_i + b_i;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues imem requests, buffers one instruction
// under decode stall and squashes in-flight fetches on redirect.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PCSrc_F,
  input  logic [N-1:0]       PCBranch_F,
  input  logic               stall_D,
  output logic               imem_req_F,
  output logic [N-1:0]       imem_addr_F,
  input  logic               imem_ack_F,
  input  logic [INSTR_W-1:0] imem_rdata_F,
  output logic               valid_D,
  output logic [INSTR_W-1:0] instr_D,
  output logic [N-1:0]       pc_D
);

  state_e               state_q, state_d;
  logic [N-1:0]         pc_q, pc_d;
  logic [N-1:0]         addr_q, addr_d;
  logic                 valid_q, valid_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [N-1:0]         pcd_q, pcd_d;
  logic [INSTR_W-1:0]   hold_instr_q, hold_instr_d;
  logic [N-1:0]         hold_pc_q, hold_pc_d;
  logic [N-1:0]         pc_inc;
  logic                 d_accept;

  adder #(
    .N (N)
  ) u_pc_adder (
    .a_i (pc_q),
    .b_i (N'(PC_INC)),
    .y_o (pc_inc)
  );

  assign d_accept = ~valid_q | ~stall_D;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    pcd_d        = pcd_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    imem_req_F   = 1'b0;

    // Decode consumes the current instruction; a load below re-asserts valid.
    if (d_accept) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StBoot: begin
        state_d = StReq;
        addr_d  = pc_q;
      end
      StReq: begin
        imem_req_F = 1'b1;
        if (imem_ack_F && !PCSrc_F) begin
          pc_d = pc_inc;
          if (d_accept) begin
            valid_d = 1'b1;
            instr_d = imem_rdata_F;
            pcd_d   = addr_q;
            addr_d  = pc_inc;
          end else begin
            hold_instr_d = imem_rdata_F;
            hold_pc_d    = addr_q;
            state_d      = StHold;
          end
        end
      end
      StHold: begin
        if (d_accept) begin
          valid_d      = 1'b1;
          instr_d      = hold_instr_q;
          pcd_d        = hold_pc_q;
          hold_instr_d = '0;
          hold_pc_d    = '0;
          addr_d       = pc_q;
          state_d      = StReq;
        end
      end
      StDrop: begin
        imem_req_F = 1'b1;
        if (imem_ack_F) begin
          addr_d  = pc_q;
          state_d = StReq;
        end
      end
      default: state_d = StBoot;
    endcase

    // Redirect overrides everything above; an unacked request must still drain.
    if (PCSrc_F) begin
      pc_d         = PCBranch_F;
      valid_d      = 1'b0;
      hold_instr_d = '0;
      hold_pc_d    = '0;
      case (state_q)
        StReq: begin
          if (imem_ack_F) begin
            addr_d  = PCBranch_F;
            state_d = StReq;
          end else begin
            state_d = StDrop;
          end
        end
        StDrop: begin
          if (imem_ack_F) begin
            addr_d = PCBranch_F;
          end
        end
        default: begin
          addr_d  = PCBranch_F;
          state_d = StReq;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StBoot;
      pc_q         <= '0;
      addr_q       <= '0;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      pcd_q        <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pcd_q        <= pcd_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  assign imem_addr_F = addr_q;
  assign valid_D     = valid_q;
  assign instr_D     = instr_q;
  assign pc_D        = pcd_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with a hand-driven memory.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int unsigned N = 64;
  localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

  logic          clk = 1'b0;
  logic          reset;
  logic          PCSrc_F;
  logic [N-1:0]  PCBranch_F;
  logic          stall_D;
  logic          imem_req_F;
  logic [N-1:0]  imem_addr_F;
  logic          imem_ack_F;
  logic [31:0]   imem_rdata_F;
  logic          valid_D;
  logic [31:0]   instr_D;
  logic [N-1:0]  pc_D;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ctrl #(
    .N (N)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .PCSrc_F      (PCSrc_F),
    .PCBranch_F   (PCBranch_F),
    .stall_D      (stall_D),
    .imem_req_F   (imem_req_F),
    .imem_addr_F  (imem_addr_F),
    .imem_ack_F   (imem_ack_F),
    .imem_rdata_F (imem_rdata_F),
    .valid_D      (valid_D),
    .instr_D      (instr_D),
    .pc_D         (pc_D)
  );

  always #5 clk = ~clk;

  // Memory contents: each word is tagged with its own address.
  function automatic logic [31:0] ifn(input logic [63:0] a);
    return 32'hC0DE_0000 ^ a[31:0];
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic src, input logic [63:0] br, input logic stl, input logic ack);
    PCSrc_F      = src;
    PCBranch_F   = br;
    stall_D      = stl;
    imem_ack_F   = ack;
    imem_rdata_F = ack ? ifn(imem_addr_F) : 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 64'h0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  task automatic check_d(input string tag, input logic v, input logic [63:0] pc);
    check_eq({tag, "_valid"}, 64'(valid_D), 64'(v));
    if (v) begin
      check_eq({tag, "_pc"}, pc_D, pc);
      check_eq({tag, "_instr"}, 64'(instr_D), 64'(ifn(pc)));
    end
  endtask

  initial begin
    reset = 1'b1;
    cyc(1'b0, 64'h0, 1'b0, 1'b0);
    cyc(1'b1, 64'h40, 1'b1, 1'b1);
    check_eq("rst_req", 64'(imem_req_F), 64'd0);
    check_eq("rst_addr", imem_addr_F, 64'd0);
    check_eq("rst_valid", 64'(valid_D), 64'd0);
    check_eq("rst_instr", 64'(instr_D), 64'd0);
    check_eq("rst_pcd", pc_D, 64'd0);
    check_eq("rst_state", 64'(dut.state_q), 64'(StBoot));
    reset = 1'b0;
    cyc(1'b0, 64'h0, 1'b0, 1'b0);
    check_eq("boot_req", 64'(imem_req_F), 64'd1);
    check_eq("boot_addr", imem_addr_F, 64'd0);

    // Streaming: back-to-back acks, one instruction per cycle.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 64'h0, 1'b0, 1'b1);
      check_d("stream", 1'b1, 64'(4 * i));
      check_eq("stream_addr", imem_addr_F, 64'(4 * (i + 1)));
    end
    cyc(1'b0, 64'h0, 1'b0, 1'b0);
    check_d("stream_idle", 1'b0, 64'h0);

    // Slow memory: ack on the third cycle of each request.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) begin
        check_eq("slow_addr", imem_addr_F, 64'(4 * k));
        check_eq("slow_req", 64'(imem_req_F), 64'd1);
        cyc(1'b0, 64'h0, 1'b0, j == 2);
        check_d("slow", j == 2, 64'(4 * k));
      end
    end

    // Stall: second instruction parks in the hold buffer.
    do_reset();
    cyc(1'b0, 64'h0, 1'b0, 1'b1);
    check_d("st_first", 1'b1, 64'h0);
    cyc(1'b0, 64'h0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_eq("st_state", 64'(dut.state_q), 64'(StHold));
      check_eq("st_req", 64'(imem_req_F), 64'd0);
      check_d("st_keep", 1'b1, 64'h0);
      cyc(1'b0, 64'h0, 1'b1, 1'b1);
    end
    check_d("st_keep4", 1'b1, 64'h0);
    cyc(1'b0, 64'h0, 1'b0, 1'b0);
    check_d("st_release", 1'b1, 64'h4);
    check_eq("st_addr", imem_addr_F, 64'h8);
    cyc(1'b0, 64'h0, 1'b0, 1'b1);
    check_d("st_next", 1'b1, 64'h8);
    cyc(1'b0, 64'h0, 1'b0, 1'b0);
    check_d("st_idle", 1'b0, 64'h0);

    // Redirect while request to 0x8 is outstanding.
    do_reset();
    cyc(1'b0, 64'h0, 1'b0, 1'b1);
    cyc(1'b0, 64'h0, 1'b0, 1'b1);
    check_d("rd_pre", 1'b1, 64'h4);
    cyc(1'b1, 64'h100, 1'b0, 1'b0);
    check_eq("rd_state", 64'(dut.state_q), 64'(StDrop));
    check_eq("rd_addr", imem_addr_F, 64'h8);
    check_eq("rd_req", 64'(imem_req_F), 64'd1);
    check_d("rd_kill", 1'b0, 64'h0);
    cyc(1'b0, 64'h0, 1'b0, 1'b0);
    check_eq("rd_hold_addr", imem_addr_F, 64'h8);
    cyc(1'b0, 64'h0, 1'b0, 1'b1);
    check_d("rd_discard", 1'b0, 64'h0);
    check_eq("rd_new_addr", imem_addr_F, 64'h100);
    cyc(1'b0, 64'h0, 1'b0, 1'b1);
    check_d("rd_target", 1'b1, 64'h100);

    // Redirect coinciding with ack, then two redirects while draining.
    do_reset();
    cyc(1'b0, 64'h0, 1'b0, 1'b1);
    cyc(1'b1, 64'h200, 1'b0, 1'b1);
    check_d("ra_discard", 1'b0, 64'h0);
    check_eq("ra_state", 64'(dut.state_q), 64'(StReq));
    check_eq("ra_addr", imem_addr_F, 64'h200);
    cyc(1'b0, 64'h0, 1'b0, 1'b1);
    check_d("ra_target", 1'b1, 64'h200);
    cyc(1'b1, 64'h200, 1'b0, 1'b0);
    cyc(1'b1, 64'h300, 1'b0, 1'b0);
    check_eq("dd_state", 64'(dut.state_q), 64'(StDrop));
    check_eq("dd_addr", imem_addr_F, 64'h204);
    cyc(1'b0, 64'h0, 1'b0, 1'b1);
    check_d("dd_discard", 1'b0, 64'h0);
    check_eq("dd_new_addr", imem_addr_F, 64'h300);
    cyc(1'b0, 64'h0, 1'b0, 1'b1);
    check_d("dd_target", 1'b1, 64'h300);

    // Wrap at the top of the address space, then reset mid-request.
    do_reset();
    cyc(1'b1, TOP, 1'b0, 1'b0);
    cyc(1'b0, 64'h0, 1'b0, 1'b1);
    check_eq("wr_addr", imem_addr_F, TOP);
    cyc(1'b0, 64'h0, 1'b0, 1'b1);
    check_d("wr_top", 1'b1, TOP);
    check_eq("wr_wrap", imem_addr_F, 64'h0);
    reset = 1'b1;
    cyc(1'b1, 64'h500, 1'b1, 1'b1);
    reset = 1'b0;
    check_eq("mr_state", 64'(dut.state_q), 64'(StBoot));
    check_eq("mr_req", 64'(imem_req_F), 64'd0);
    check_eq("mr_addr", imem_addr_F, 64'd0);
    check_eq("mr_valid", 64'(valid_D), 64'd0);
    check_eq("mr_instr", 64'(instr_D), 64'd0);
    check_eq("mr_pcd", pc_D, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
